// File: rtl/bcd_multi_decade_down_pkg.sv
// Shared types and constants for the multi-decade BCD down-counter.
package bcd_multi_decade_down_pkg;

  // Width of one BCD decade and its largest legal value.
  localparam int unsigned DigitW = 4;
  localparam logic [DigitW-1:0] BcdMax = 4'd9;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } state_e;

  // True when a 4-bit field holds a legal BCD digit.
  function automatic logic bcd_digit_ok(input logic [DigitW-1:0] digit);
    return digit <= BcdMax;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade: loadable, decrements on en, wraps 0 -> 9.
module bcd_down_digit
  import bcd_multi_decade_down_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DigitW-1:0] d,
  input  logic              en,
  output logic [DigitW-1:0] q,
  output logic              is_zero
);

  logic [DigitW-1:0] q_d, q_q;

  // Next digit value: load wins, otherwise decrement with wrap when enabled.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == '0) ? BcdMax : q_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign is_zero = (q_q == '0);

endmodule

// File: rtl/bcd_multi_decade_down.sv
// Multi-decade BCD down-counter with IDLE/RUN/EXPIRED control and load checking.
module bcd_multi_decade_down
  import bcd_multi_decade_down_pkg::*;
#(
  parameter int unsigned n = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*n-1:0]    D_flat,
  input  logic              enable,
  output logic [4*n-1:0]    Q_flat,
  output logic              busy,
  output logic              expired,
  output logic              fdone,
  output logic              err
);

  localparam int unsigned W = DigitW * n;

  state_e state_d, state_q;
  logic   busy_d, busy_q;
  logic   expired_d, expired_q;
  logic   fdone_d, fdone_q;
  logic   err_d, err_q;

  logic         load_valid;
  logic         load_ok;
  logic         dec;
  logic         q_is_one;
  logic [n-1:0] zero;
  logic [n:0]   lower_zero;

  // A load is accepted only if every decade is a legal BCD digit.
  always_comb begin
    load_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!bcd_digit_ok(D_flat[DigitW*i +: DigitW])) begin
        load_valid = 1'b0;
      end
    end
  end

  assign load_ok  = load & load_valid;
  // lower_zero[n] guards against ever wrapping an all-zero count to all-9s.
  assign dec      = (state_q == StRun) & enable & ~load & ~lower_zero[n];
  assign q_is_one = (Q_flat == W'(1));

  assign lower_zero[0] = 1'b1;

  for (genvar i = 0; i < n; i++) begin : g_digit
    assign lower_zero[i+1] = lower_zero[i] & zero[i];

    bcd_down_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .load    (load_ok),
      .d       (D_flat[DigitW*i +: DigitW]),
      .en      (dec & lower_zero[i]),
      .q       (Q_flat[DigitW*i +: DigitW]),
      .is_zero (zero[i])
    );
  end

  // Next state and next registered flags; load has priority over counting.
  always_comb begin
    state_d = state_q;
    fdone_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (!load_valid) begin
        err_d = 1'b1;
      end else if (D_flat == '0) begin
        state_d = StExpired;
      end else begin
        state_d = StRun;
      end
    end else if (dec && q_is_one) begin
      state_d = StExpired;
      fdone_d = 1'b1;
    end
    busy_d    = (state_d == StRun);
    expired_d = (state_d == StExpired);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      fdone_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      fdone_q   <= fdone_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign expired = expired_q;
  assign fdone   = fdone_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_multi_decade_down.sv
// Directed bench for bcd_multi_decade_down (n = 3).
// Observed vector is {Q_flat, busy, expired, fdone, err}.
module tb_bcd_multi_decade_down;

  logic        clk;
  logic        reset;
  logic        load;
  logic [11:0] D_flat;
  logic        enable;
  logic [11:0] Q_flat;
  logic        busy;
  logic        expired;
  logic        fdone;
  logic        err;
  logic [15:0] obs;

  int checks;
  int errors;

  bcd_multi_decade_down #(.n(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .D_flat  (D_flat),
    .enable  (enable),
    .Q_flat  (Q_flat),
    .busy    (busy),
    .expired (expired),
    .fdone   (fdone),
    .err     (err)
  );

  assign obs = {Q_flat, busy, expired, fdone, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; D_flat = '0; enable = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {12'h000, 4'b0000}) begin
      $display("FAIL reset_state: got %h want %h", obs, {12'h000, 4'b0000});
      errors++;
    end
    tick();
    reset = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0000}) begin
      $display("FAIL idle_ignores_enable: got %h want %h", obs, {12'h000, 4'b0000});
      errors++;
    end
    // Illegal digit while idle: err pulse, still idle.
    load = 1'b1; D_flat = 12'h00F;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {12'h000, 4'b0001}) begin
      $display("FAIL idle_bad_load: got %h want %h", obs, {12'h000, 4'b0001});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0000}) begin
      $display("FAIL idle_err_clears: got %h want %h", obs, {12'h000, 4'b0000});
      errors++;
    end
  endtask

  task automatic test_decade_wrap();
    logic [11:0] exp_q [7];
    exp_q = '{12'h104, 12'h103, 12'h102, 12'h101, 12'h100, 12'h099, 12'h098};
    load = 1'b1; D_flat = 12'h105; enable = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {12'h105, 4'b1000}) begin
      $display("FAIL wrap_load: got %h want %h", obs, {12'h105, 4'b1000});
      errors++;
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs !== {exp_q[i], 4'b1000}) begin
        $display("FAIL wrap_step%0d: got %h want %h", i, obs, {exp_q[i], 4'b1000});
        errors++;
      end
    end
    // Hold with enable low.
    enable = 1'b0;
    tick();
    checks++;
    if (obs !== {12'h098, 4'b1000}) begin
      $display("FAIL run_hold: got %h want %h", obs, {12'h098, 4'b1000});
      errors++;
    end
  endtask

  task automatic test_terminal();
    load = 1'b1; D_flat = 12'h002; enable = 1'b1;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (obs !== {12'h001, 4'b1000}) begin
      $display("FAIL term_001: got %h want %h", obs, {12'h001, 4'b1000});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0110}) begin
      $display("FAIL term_000_fdone: got %h want %h", obs, {12'h000, 4'b0110});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0100}) begin
      $display("FAIL term_fdone_once: got %h want %h", obs, {12'h000, 4'b0100});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0100}) begin
      $display("FAIL expired_no_wrap: got %h want %h", obs, {12'h000, 4'b0100});
      errors++;
    end
    enable = 1'b0;
  endtask

  task automatic test_reject();
    load = 1'b1; D_flat = 12'h050;
    tick();
    load = 1'b1; D_flat = 12'h1A3; enable = 1'b1;
    tick();
    load = 1'b0; enable = 1'b0;
    checks++;
    if (obs !== {12'h050, 4'b1001}) begin
      $display("FAIL reject_err: got %h want %h", obs, {12'h050, 4'b1001});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h050, 4'b1000}) begin
      $display("FAIL reject_err_once: got %h want %h", obs, {12'h050, 4'b1000});
      errors++;
    end
  endtask

  task automatic test_zero_load();
    load = 1'b1; D_flat = 12'h000;
    tick();
    load = 1'b0; enable = 1'b1;
    checks++;
    if (obs !== {12'h000, 4'b0100}) begin
      $display("FAIL zero_load: got %h want %h", obs, {12'h000, 4'b0100});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0100}) begin
      $display("FAIL zero_load_no_fdone: got %h want %h", obs, {12'h000, 4'b0100});
      errors++;
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Exit EXPIRED by a valid load, then load on the terminal edge.
    load = 1'b1; D_flat = 12'h001;
    tick();
    checks++;
    if (obs !== {12'h001, 4'b1000}) begin
      $display("FAIL reload_from_expired: got %h want %h", obs, {12'h001, 4'b1000});
      errors++;
    end
    load = 1'b1; D_flat = 12'h300; enable = 1'b1;
    tick();
    load = 1'b0; enable = 1'b0;
    checks++;
    if (obs !== {12'h300, 4'b1000}) begin
      $display("FAIL load_beats_terminal: got %h want %h", obs, {12'h300, 4'b1000});
      errors++;
    end
    tick();
    checks++;
    if (obs !== {12'h300, 4'b1000}) begin
      $display("FAIL load_beats_terminal_after: got %h want %h", obs, {12'h300, 4'b1000});
      errors++;
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; D_flat = 12'h742; enable = 1'b1;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (obs !== {12'h741, 4'b1000}) begin
      $display("FAIL pre_reset_count: got %h want %h", obs, {12'h741, 4'b1000});
      errors++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {12'h000, 4'b0000}) begin
      $display("FAIL async_reset: got %h want %h", obs, {12'h000, 4'b0000});
      errors++;
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== {12'h000, 4'b0000}) begin
      $display("FAIL post_reset_enable: got %h want %h", obs, {12'h000, 4'b0000});
      errors++;
    end
    enable = 1'b0;
    // First edge after release handles a load normally.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    load = 1'b1; D_flat = 12'h005;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {12'h005, 4'b1000}) begin
      $display("FAIL first_edge_load: got %h want %h", obs, {12'h005, 4'b1000});
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decade_wrap();
    test_terminal();
    test_reject();
    test_zero_load();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_multi_decade_down.md
BCD_MULTI_DECADE_DOWN -- requirements
Module: bcd_multi_decade_down

Interface
REQ-001 Parameter: n, default 3, number of BCD decades (n >= 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  load request; samples D_flat on the same edge.
REQ-005 D_flat  input  4*n  load value; decade i at bits [4*i+3:4*i], decade 0 least significant.
REQ-006 enable  input  1  count-down tick; one decrement per sampled-high cycle in RUN.
REQ-007 Q_flat  output  4*n  current count, same packing as D_flat.
REQ-008 busy  output  1  high while in RUN.
REQ-009 expired  output  1  high while in EXPIRED.
REQ-010 fdone  output  1  one-cycle pulse on terminal count.
REQ-011 err  output  1  one-cycle pulse on rejected load.

Function
REQ-012 FSM states SHALL be IDLE, RUN, EXPIRED; all outputs SHALL be registered.
REQ-013 load SHALL have priority over enable in every state.
REQ-014 Load check: every decade of D_flat SHALL be <= 9, else the load is rejected.
REQ-015 Valid, nonzero load: Q_flat <= D_flat, next state RUN, in any state.
REQ-016 Valid, all-zero load: Q_flat <= 0, next state EXPIRED, fdone not pulsed.
REQ-017 Rejected load: Q_flat and state unchanged, err high exactly the next cycle.
REQ-018 RUN, enable=1, load=0: Q_flat SHALL decrement by 1 in BCD within one cycle.
REQ-019 BCD borrow: decade 0 decrements when enabled; a decade at 0 wraps to 9 and borrows from decade i+1; decade i is enabled only if all lower decades are 0.
REQ-020 RUN, enable=0: Q_flat and state hold.
REQ-021 RUN, Q_flat=1, enable=1: Q_flat <= 0, next state EXPIRED, fdone high exactly the next cycle.
REQ-022 EXPIRED: Q_flat holds 0; enable ignored; no wrap to all-9s; exit only via valid load.
REQ-023 IDLE: Q_flat holds 0; enable ignored; exit only via valid load.
REQ-024 fdone and err SHALL never assert in the same cycle, and neither SHALL hold for more than one cycle per event.
REQ-025 Load on the same edge as the terminal decrement SHALL win; fdone not pulsed.

Reset
REQ-026 reset high SHALL immediately force state IDLE, Q_flat=0, busy=0, expired=0, fdone=0, err=0, regardless of clk.
REQ-027 Reset mid-count SHALL discard the count; no fdone after release.
REQ-028 After reset deassertion, the first rising edge SHALL process load/enable normally.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE, RUN, EXPIRED) and the BCD constants (BCD_MAX = 9, 4-bit decade width).
REQ-030 One sub-module, bcd_down_digit, SHALL implement a single decade: inputs clk, reset, load, d[3:0], en; outputs q[3:0], is_zero; n instances chained through the borrow-enable chain.
REQ-031 The borrow-enable chain SHALL be combinational within a cycle; no extra pipeline latency per decade.

Verification
REQ-032 n=3: load 0x105, enable held high -> Q_flat 104,103,102,101,100,099,098 on successive cycles (decade wrap correct).
REQ-033 n=3: load 0x002, enable high -> Q_flat 001 then 000; fdone high the one cycle Q_flat first reads 000; expired=1, busy=0; further enables keep 000.
REQ-034 n=3: load 0x1A3 in RUN at 0x050 -> Q_flat stays 050, err pulses one cycle, busy stays 1.
REQ-035 n=3: load 0x000 -> expired=1 next cycle, fdone never asserts.
REQ-036 n=3: at Q_flat=001, assert load 0x300 and enable together -> Q_flat=300, busy=1, no fdone.
REQ-037 n=3: reset asserted asynchronously mid-count at 0x742 -> Q_flat=000, IDLE, all flags 0 before next clk edge; enable after release has no effect.
